// File: rtl/ascii_to_ps2_tx.sv
// PS/2 device-side transmitter: maps ASCII to Set-2 scancodes and sends
// make, break prefix (F0) and break frames on registered clock/data lines.
module ascii_to_ps2_tx #(
  parameter int unsigned HALF_PERIOD = 2500,
  parameter int unsigned GAP_CYCLES  = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ascii,
  input  logic       ascii_valid,
  output logic       ascii_ready,
  output logic       unsupported,
  output logic       busy,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam int unsigned MAX_CNT = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned FRM_W   = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BIT_HIGH = 2'd1,
    BIT_LOW  = 2'd2,
    GAP      = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [BIT_W-1:0]   bit_idx, bit_nxt;
  logic [FRM_W-1:0]   frame_idx, frame_nxt;
  logic [7:0]         code, code_nxt;
  logic               ps2_clk_nxt, ps2_data_nxt, busy_nxt, ready_nxt, unsup_nxt;
  logic [8:0]         mapped;
  logic [7:0]         payload;
  logic [10:0]        frame_bits;

  // Returns {supported, scancode}; lowercase folds onto uppercase.
  function automatic logic [8:0] map_ascii(input logic [7:0] a);
    logic [7:0] u;
    u = (a >= 8'h61 && a <= 8'h7A) ? (a - 8'h20) : a;
    case (u)
      8'h41: map_ascii = {1'b1, 8'h1C};
      8'h42: map_ascii = {1'b1, 8'h32};
      8'h43: map_ascii = {1'b1, 8'h21};
      8'h44: map_ascii = {1'b1, 8'h23};
      8'h45: map_ascii = {1'b1, 8'h24};
      8'h46: map_ascii = {1'b1, 8'h2B};
      8'h47: map_ascii = {1'b1, 8'h34};
      8'h48: map_ascii = {1'b1, 8'h33};
      8'h49: map_ascii = {1'b1, 8'h43};
      8'h4A: map_ascii = {1'b1, 8'h3B};
      8'h4B: map_ascii = {1'b1, 8'h42};
      8'h4C: map_ascii = {1'b1, 8'h4B};
      8'h4D: map_ascii = {1'b1, 8'h3A};
      8'h4E: map_ascii = {1'b1, 8'h31};
      8'h4F: map_ascii = {1'b1, 8'h44};
      8'h50: map_ascii = {1'b1, 8'h4D};
      8'h51: map_ascii = {1'b1, 8'h15};
      8'h52: map_ascii = {1'b1, 8'h2D};
      8'h53: map_ascii = {1'b1, 8'h1B};
      8'h54: map_ascii = {1'b1, 8'h2C};
      8'h55: map_ascii = {1'b1, 8'h3C};
      8'h56: map_ascii = {1'b1, 8'h2A};
      8'h57: map_ascii = {1'b1, 8'h1D};
      8'h58: map_ascii = {1'b1, 8'h22};
      8'h59: map_ascii = {1'b1, 8'h35};
      8'h5A: map_ascii = {1'b1, 8'h1A};
      8'h30: map_ascii = {1'b1, 8'h70};
      8'h31: map_ascii = {1'b1, 8'h69};
      8'h32: map_ascii = {1'b1, 8'h72};
      8'h33: map_ascii = {1'b1, 8'h7A};
      8'h34: map_ascii = {1'b1, 8'h6B};
      8'h35: map_ascii = {1'b1, 8'h73};
      8'h36: map_ascii = {1'b1, 8'h74};
      8'h37: map_ascii = {1'b1, 8'h6C};
      8'h38: map_ascii = {1'b1, 8'h75};
      8'h39: map_ascii = {1'b1, 8'h7D};
      default: map_ascii = 9'h000;
    endcase
  endfunction

  assign mapped = map_ascii(ascii);

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      frame_idx   <= '0;
      code        <= '0;
      ps2_clk     <= 1'b1;
      ps2_data    <= 1'b1;
      busy        <= 1'b0;
      ascii_ready <= 1'b1;
      unsupported <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      bit_idx     <= bit_nxt;
      frame_idx   <= frame_nxt;
      code        <= code_nxt;
      ps2_clk     <= ps2_clk_nxt;
      ps2_data    <= ps2_data_nxt;
      busy        <= busy_nxt;
      ascii_ready <= ready_nxt;
      unsupported <= unsup_nxt;
    end
  end

  // Next state: one down-counter times every clock phase and gap.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    frame_nxt = frame_idx;
    code_nxt  = code;
    case (state)
      IDLE: begin
        if (ascii_valid && mapped[8]) begin
          state_nxt = BIT_HIGH;
          cnt_nxt   = CNT_W'(HALF_PERIOD - 1);
          bit_nxt   = '0;
          frame_nxt = '0;
          code_nxt  = mapped[7:0];
        end
      end
      BIT_HIGH: begin
        if (cnt == '0) begin
          state_nxt = BIT_LOW;
          cnt_nxt   = CNT_W'(HALF_PERIOD - 1);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      BIT_LOW: begin
        if (cnt == '0) begin
          if (bit_idx == BIT_W'(10)) begin
            state_nxt = GAP;
            cnt_nxt   = CNT_W'(GAP_CYCLES - 1);
          end else begin
            state_nxt = BIT_HIGH;
            cnt_nxt   = CNT_W'(HALF_PERIOD - 1);
            bit_nxt   = bit_idx + BIT_W'(1);
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          if (frame_idx == FRM_W'(2)) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = BIT_HIGH;
            cnt_nxt   = CNT_W'(HALF_PERIOD - 1);
            bit_nxt   = '0;
            frame_nxt = frame_idx + FRM_W'(1);
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    payload      = (frame_nxt == FRM_W'(1)) ? 8'hF0 : code_nxt;
    frame_bits   = {1'b1, ~^payload, payload, 1'b0};
    ps2_clk_nxt  = (state_nxt != BIT_LOW);
    ps2_data_nxt = 1'b1;
    if (state_nxt == BIT_HIGH || state_nxt == BIT_LOW) begin
      ps2_data_nxt = frame_bits[bit_nxt];
    end
    busy_nxt  = (state_nxt != IDLE);
    ready_nxt = (state_nxt == IDLE);
    unsup_nxt = (state == IDLE) && ascii_valid && !mapped[8];
  end

endmodule
